uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer placed directly downstream of uart_receiver.

---
 rtl/uart_rx_fifo.sv | 100 ++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side circular byte buffer behind uart_receiver.
// Each rising edge of rx_done writes one byte; the consumer reads the head
// over a first-word-fall-through valid/ready port. A sticky flag records
// any frame that was dropped because the buffer was full.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rd_ready,
  input  logic              ovf_clr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rx_done_q;
  logic              r_overflow;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_wr_en;

  // A frame is captured once, on the cycle rx_done rises.
  assign w_push  = rx_done & ~r_rx_done_q;
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & rd_ready;
  // When full, a push is only accepted if the head leaves in the same cycle.
  assign w_wr_en = w_push & (~w_full | w_pop);

  assign rd_valid = ~w_empty;
  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;

  // Storage write port.
  // NOTE: the data array has no reset; empty/valid come from r_count, so stale
  // entries are never observable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= rx_data;
  end

  // Edge detector for rx_done; held at 1 in reset so a high level at release is ignored.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_done_q <= 1'b1;
    else     r_rx_done_q <= rx_done;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Fill level: a simultaneous write and read leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_overflow <= 1'b0;
    else if (w_push & w_full & ~w_pop)  r_overflow <= 1'b1;
    else if (ovf_clr)                   r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model is
// compared against every output on each falling edge, alongside directed
// scenarios with literal expected values.
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic [DATA_W-1:0] rx_data  = '0;
  logic              rx_done  = 1'b0;
  logic              rd_ready = 1'b0;
  logic              ovf_clr  = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;

  int n_pass  = 0;
  int n_total = 0;
  bit compare_en = 1'b0;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rd_ready (rd_ready),
    .ovf_clr  (ovf_clr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_q[$];
  bit                m_prev_done = 1'b1;
  bit                m_ovf       = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_prev_done = 1'b1;
      m_ovf       = 1'b0;
    end else begin
      bit push, pop, was_full;
      push     = rx_done && !m_prev_done;
      pop      = (m_q.size() > 0) && rd_ready;
      was_full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (push && was_full && !pop) m_ovf = 1'b1;
      else if (ovf_clr)             m_ovf = 1'b0;
      if (push && !(was_full && !pop)) m_q.push_back(rx_data);
      m_prev_done = rx_done;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (compare_en) begin
      check("m_count",    32'(count),    32'(m_q.size()));
      check("m_empty",    32'(empty),    32'(m_q.size() == 0));
      check("m_full",     32'(full),     32'(m_q.size() == DEPTH));
      check("m_rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
      check("m_rd_data",  32'(rd_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      check("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  logic [DATA_W-1:0] rd_log[$];

  initial begin
    // Reset state with rx_done low.
    #1;
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    compare_en = 1'b1;

    // 1: two bytes then drain.
    push_byte(8'hAA);
    push_byte(8'hF0);
    check("t1_count",    32'(count),    32'd2);
    check("t1_rd_valid", 32'(rd_valid), 32'd1);
    check("t1_rd_data",  32'(rd_data),  32'hAA);
    pop_one();
    check("t1_pop1_data",  32'(rd_data), 32'hF0);
    check("t1_pop1_count", 32'(count),   32'd1);
    pop_one();
    check("t1_pop2_empty", 32'(empty),   32'd1);
    check("t1_pop2_data",  32'(rd_data), 32'h00);

    // 2: long rx_done pulse writes once.
    rx_data = 8'h3C;
    rx_done = 1'b1;
    repeat (5) tick();
    check("t2_hold_count", 32'(count), 32'd1);
    rx_done = 1'b0;
    tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    check("t2_second_count", 32'(count), 32'd2);
    pop_one();
    pop_one();
    check("t2_drained", 32'(empty), 32'd1);

    // 3: fill, overflow, clear/set collision, drain, clear.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("t3_full",  32'(full),  32'd1);
    check("t3_count", 32'(count), 32'd16);
    push_byte(8'h55);
    check("t3_ovf",       32'(overflow), 32'd1);
    check("t3_ovf_count", 32'(count),    32'd16);
    rx_data = 8'h55;
    rx_done = 1'b1;
    ovf_clr = 1'b1;
    tick();
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    tick();
    check("t3_set_wins", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_drain_data", 32'(rd_data), 32'(i));
      pop_one();
    end
    check("t3_drained", 32'(empty), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // 4: push and pop together while full.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    rx_data  = 8'h77;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    check("t4_count", 32'(count),    32'd16);
    check("t4_ovf",   32'(overflow), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      check("t4_drain_data", 32'(rd_data), (i == DEPTH) ? 32'h77 : 32'(i));
      pop_one();
    end
    check("t4_drained", 32'(empty), 32'd1);

    // 5: wrap with random consumer back-pressure.
    begin
      int wr_idx = 0;
      int cyc    = 0;
      rd_log.delete();
      while ((wr_idx < 40 || rd_valid) && cyc < 1000) begin
        if (wr_idx < 40 && !rx_done) begin
          rx_data = 8'((wr_idx * 7) % 256);
          rx_done = 1'b1;
          wr_idx++;
        end else begin
          rx_done = 1'b0;
        end
        rd_ready = (count >= 12 || wr_idx >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
        if (rd_valid && rd_ready) rd_log.push_back(rd_data);
        tick();
        cyc++;
      end
      rx_done  = 1'b0;
      rd_ready = 1'b0;
      tick();
      check("t5_done_in_budget", 32'(cyc < 1000), 32'd1);
      check("t5_read_len",       32'(rd_log.size()), 32'd40);
      for (int i = 0; i < rd_log.size() && i < 40; i++)
        check("t5_stream", 32'(rd_log[i]), 32'((i * 7) % 256));
      check("t5_no_ovf", 32'(overflow), 32'd0);
    end

    // 6: asynchronous reset mid-operation.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i + 1));
    push_byte(8'hEE);
    repeat (11) pop_one();
    check("t6_pre_count", 32'(count),    32'd5);
    check("t6_pre_ovf",   32'(overflow), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count",    32'(count),    32'd0);
    check("t6_rst_empty",    32'(empty),    32'd1);
    check("t6_rst_ovf",      32'(overflow), 32'd0);
    check("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_rd_data",  32'(rd_data),  32'd0);
    #1 rst = 1'b0;
    tick();
    push_byte(8'h99);
    check("t6_after_data",  32'(rd_data), 32'h99);
    check("t6_after_count", 32'(count),   32'd1);
    tick();

    compare_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
